// File: rtl/adc_trigger_capture.sv
// Decimated ADC sampler with a circular pre-trigger buffer and level/forced trigger.
// Once the post-trigger window is full, the record is streamed out oldest-first on a valid/ready port.
module adc_trigger_capture #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 256,
  parameter int PRETRIG = 64,
  parameter int DECIM_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  adc_in,
  input  logic               arm,
  input  logic               force_trig,
  input  logic [DATA_W-1:0]  trig_level,
  input  logic               trig_falling,
  input  logic [DECIM_W-1:0] decim,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               triggered,
  output logic               done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   POST_LEN  = (AW+1)'(DEPTH - PRETRIG);
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRETRIG - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    READOUT
  } stateT;

  stateT state, stateNext;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DECIM_W-1:0] decimLatched;
  logic [DECIM_W-1:0] decimCnt;
  logic [AW-1:0]      wrPtr;
  logic [AW-1:0]      preCnt;
  logic [AW:0]        postCnt;
  logic [AW:0]        rdCnt;
  logic [DATA_W-1:0]  prevSample;
  logic               prevOk;
  logic               triggeredQ;
  logic [DATA_W-1:0]  outDataQ;
  logic               outValidQ;
  logic               outLastQ;

  logic          sampling;
  logic          stb;
  logic          riseHit;
  logic          fallHit;
  logic          trigHit;
  logic          accept;
  logic          lastAccept;
  logic          advance;
  logic [AW-1:0] rdAddr;

  assign sampling   = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
  assign stb        = sampling && (decimCnt == decimLatched);
  assign riseHit    = prevOk && (prevSample < trig_level) && (adc_in >= trig_level);
  assign fallHit    = prevOk && (prevSample > trig_level) && (adc_in <= trig_level);
  assign trigHit    = stb && (state == WAIT_TRIG) &&
                      (force_trig || (trig_falling ? fallHit : riseHit));
  assign accept     = outValidQ && out_ready;
  assign lastAccept = accept && outLastQ;
  // The output register doubles as the RAM read register; it reloads whenever it is empty or being taken.
  assign advance    = (state == READOUT) && (!outValidQ || out_ready) && (rdCnt != DEPTH_CNT);
  // After the final write wrPtr addresses the oldest sample, so readout starts there.
  assign rdAddr     = wrPtr + rdCnt[AW-1:0];

  // NOTE: the FSM register uses non-blocking assignment; the next-state logic below is purely combinational.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // NOTE: stateNext gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:      if (arm) stateNext = PRE;
      PRE:       if (stb && (preCnt == PRE_LAST)) stateNext = WAIT_TRIG;
      WAIT_TRIG: if (trigHit) stateNext = (POST_LEN == (AW+1)'(1)) ? READOUT : POST;
      POST:      if (stb && ((postCnt + (AW+1)'(1)) == POST_LEN)) stateNext = READOUT;
      READOUT:   if (lastAccept) stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  // NOTE: the sample buffer has no reset; its contents are fully rewritten before any readout.
  always_ff @(posedge clk) begin
    if (stb) mem[wrPtr] <= adc_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      decimLatched <= '0;
      decimCnt     <= '0;
      wrPtr        <= '0;
      preCnt       <= '0;
      postCnt      <= '0;
      rdCnt        <= '0;
      prevSample   <= '0;
      prevOk       <= 1'b0;
      triggeredQ   <= 1'b0;
      outDataQ     <= '0;
      outValidQ    <= 1'b0;
      outLastQ     <= 1'b0;
    end else begin
      if ((state == IDLE) && arm) begin
        decimLatched <= decim;
        decimCnt     <= '0;
        preCnt       <= '0;
        rdCnt        <= '0;
      end else if (sampling) begin
        decimCnt <= stb ? '0 : decimCnt + DECIM_W'(1);
      end

      if (stb) begin
        wrPtr      <= wrPtr + AW'(1);
        prevSample <= adc_in;
        prevOk     <= 1'b1;
      end

      if (stb && (state == PRE)) preCnt <= preCnt + AW'(1);

      if (trigHit) begin
        triggeredQ <= 1'b1;
        postCnt    <= (AW+1)'(1);
      end else if (stb && (state == POST)) begin
        postCnt <= postCnt + (AW+1)'(1);
      end

      if (advance) begin
        outDataQ  <= mem[rdAddr];
        outValidQ <= 1'b1;
        outLastQ  <= (rdCnt == DEPTH_CNT - (AW+1)'(1));
        rdCnt     <= rdCnt + (AW+1)'(1);
      end else if (accept) begin
        outValidQ <= 1'b0;
        outLastQ  <= 1'b0;
      end

      if (lastAccept) triggeredQ <= 1'b0;
    end
  end

  assign out_data  = outDataQ;
  assign out_valid = outValidQ;
  assign out_last  = outLastQ;
  assign busy      = (state != IDLE);
  assign triggered = triggeredQ;
  assign done      = lastAccept;

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Directed and randomized captures of adc_trigger_capture (DEPTH=16, PRETRIG=4) against a
// sample-list reference model: strobe times -> sample list -> trigger index -> expected record.
module tb_adc_trigger_capture;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int PRETRIG = 4;
  localparam int DECIM_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [DATA_W-1:0]  adc_in;
  logic               arm;
  logic               force_trig;
  logic [DATA_W-1:0]  trig_level;
  logic               trig_falling;
  logic [DECIM_W-1:0] decim;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               busy;
  logic               triggered;
  logic               done;

  adc_trigger_capture #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PRETRIG(PRETRIG),
    .DECIM_W(DECIM_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .adc_in      (adc_in),
    .arm         (arm),
    .force_trig  (force_trig),
    .trig_level  (trig_level),
    .trig_falling(trig_falling),
    .decim       (decim),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .triggered   (triggered),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = 0;        // 0 ramp up, 1 ramp down, 2 constant 0x20, 3 random
  bit readyRand = 1'b0;

  logic [7:0] adcLog[$];
  bit         forceLog[$];
  logic [7:0] got[$];
  int         donePulses;
  bit         heldValid = 1'b0;
  logic [7:0] heldData;
  logic       heldLast;
  logic [7:0] expRec[DEPTH];
  bit         expFound;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] rampVal();
    return (mode == 1) ? 8'hFF - 8'(cyc) : 8'(cyc);
  endfunction

  // One clock: drive inputs at negedge, observe outputs 1ns later, well before the next posedge.
  task automatic tick(input bit a, input bit f, input bit r);
    int idx;
    @(negedge clk);
    case (mode)
      0, 1:    adc_in = rampVal();
      2:       adc_in = 8'h20;
      default: adc_in = 8'($urandom);
    endcase
    arm        = a;
    force_trig = f;
    rst        = r;
    out_ready  = readyRand ? 1'($urandom_range(0, 1)) : 1'b1;
    adcLog.push_back(adc_in);
    forceLog.push_back(f);
    cyc++;
    #1;
    if (heldValid) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, heldData);
      check("hold_last", out_last, heldLast);
    end
    if (!r) begin
      if (done === 1'b1) donePulses++;
      if (out_valid && out_ready) begin
        idx = got.size();
        check($sformatf("last_flag[%0d]", idx), out_last, idx == DEPTH - 1);
        check($sformatf("done_at[%0d]", idx), done, idx == DEPTH - 1);
        if (idx == 0) begin
          check("triggered_in_readout", triggered, 1);
          check("busy_in_readout", busy, 1);
        end
        got.push_back(out_data);
      end else begin
        check("done_quiet", done, 0);
      end
    end
    heldValid = out_valid && !out_ready && !r;
    heldData  = out_data;
    heldLast  = out_last;
  endtask

  // Reference model: take the logged inputs at each strobe edge, find the first qualifying
  // trigger after the pre-trigger samples, and cut the DEPTH-sample window around it.
  task automatic buildExpected(input int d, input logic [7:0] lvl, input bit fall);
    logic [7:0] s[$];
    bit         fl[$];
    bit         hit;
    int         t;
    s.delete();
    fl.delete();
    for (int e = d + 1; e < adcLog.size(); e += d + 1) begin
      s.push_back(adcLog[e]);
      fl.push_back(forceLog[e]);
    end
    expFound = 1'b0;
    t = 0;
    for (int k = PRETRIG; k < s.size() && !expFound; k++) begin
      hit = fl[k] || (fall ? (s[k-1] > lvl && s[k] <= lvl) : (s[k-1] < lvl && s[k] >= lvl));
      if (hit) begin
        expFound = 1'b1;
        t = k;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      expRec[i] = (expFound && (t - PRETRIG + i) < s.size()) ? s[t - PRETRIG + i] : 8'hxx;
    end
  endtask

  task automatic startCapture(input int m, input int d, input logic [7:0] lvl, input bit fall,
                              input logic [7:0] startVal, input bit waitStart);
    mode         = m;
    decim        = DECIM_W'(d);
    trig_level   = lvl;
    trig_falling = fall;
    if (waitStart) begin
      for (int n = 0; n < 300 && rampVal() != startVal; n++) tick(0, 0, 0);
    end
    adcLog.delete();
    forceLog.delete();
    got.delete();
    donePulses = 0;
    tick(1, 0, 0);
  endtask

  task automatic runCapture(input string name, input int d, input logic [7:0] lvl, input bit fall,
                            input bit spur);
    bit didPost;
    bit didRead;
    bit a;
    int n;
    didPost = 1'b0;
    didRead = 1'b0;
    n = 0;
    while (got.size() < DEPTH && n < 4000) begin
      a = 1'b0;
      if (spur && !didPost && triggered === 1'b1 && out_valid === 1'b0) begin
        a = 1'b1;
        didPost = 1'b1;
      end else if (spur && !didRead && got.size() == 3) begin
        a = 1'b1;
        didRead = 1'b1;
      end
      tick(a, 0, 0);
      n++;
    end
    check({name, "_word_count"}, got.size(), DEPTH);
    tick(0, 0, 0);
    check({name, "_busy_after"}, busy, 0);
    check({name, "_trig_after"}, triggered, 0);
    check({name, "_done_pulses"}, donePulses, 1);
    buildExpected(d, lvl, fall);
    check({name, "_model_trigger"}, expFound, 1);
    for (int i = 0; i < DEPTH && i < got.size(); i++) begin
      check($sformatf("%s_word[%0d]", name, i), got[i], expRec[i]);
    end
    if (spur) begin
      repeat (3) tick(0, 0, 0);
      check({name, "_no_rearm"}, busy, 0);
    end
  endtask

  initial begin
    int d;
    logic [7:0] lvl;
    bit fall;
    int n;

    rst          = 1'b1;
    arm          = 1'b0;
    force_trig   = 1'b0;
    adc_in       = '0;
    trig_level   = 8'h80;
    trig_falling = 1'b0;
    decim        = '0;
    out_ready    = 1'b0;
    repeat (3) @(posedge clk);
    tick(0, 0, 1);
    tick(0, 0, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_triggered", triggered, 0);
    check("rst_done", done, 0);

    // Rising ramp, every clock.
    startCapture(0, 0, 8'h80, 0, 8'h10, 1);
    runCapture("ramp", 0, 8'h80, 0, 0);
    if (got.size() == DEPTH) begin
      check("ramp_first", got[0], 8'h7C);
      check("ramp_last", got[DEPTH-1], 8'h8B);
    end

    // Rising ramp, strobe every 4 clocks.
    startCapture(0, 3, 8'h80, 0, 8'h10, 1);
    runCapture("decim3", 3, 8'h80, 0, 0);
    if (got.size() == DEPTH) begin
      check("decim3_first", got[0], 8'h70);
      check("decim3_last", got[DEPTH-1], 8'hAC);
    end

    // Falling ramp.
    startCapture(1, 0, 8'h40, 1, 8'hF0, 1);
    runCapture("fall", 0, 8'h40, 1, 0);
    if (got.size() == DEPTH) begin
      check("fall_first", got[0], 8'h44);
      check("fall_trig_sample", got[PRETRIG], 8'h40);
      check("fall_last", got[DEPTH-1], 8'h35);
    end

    // Constant input never crosses; force ends the wait.
    startCapture(2, 0, 8'h80, 0, 8'h00, 0);
    repeat (1000) tick(0, 0, 0);
    check("const_busy", busy, 1);
    check("const_not_triggered", triggered, 0);
    tick(0, 1, 0);
    runCapture("force", 0, 8'h80, 0, 0);
    if (got.size() == DEPTH) check("force_word0", got[0], 8'h20);

    // Backpressure on the ramp capture.
    readyRand = 1'b1;
    startCapture(0, 0, 8'h80, 0, 8'h10, 1);
    runCapture("bp", 0, 8'h80, 0, 0);
    readyRand = 1'b0;

    // Stray arm pulses during POST and READOUT.
    startCapture(0, 0, 8'h80, 0, 8'h10, 1);
    runCapture("spur", 0, 8'h80, 0, 1);

    // Reset in the middle of readout.
    readyRand = 1'b1;
    startCapture(0, 0, 8'h80, 0, 8'h10, 1);
    n = 0;
    while (got.size() < 5 && n < 2000) begin
      tick(0, 0, 0);
      n++;
    end
    check("midrst_reached", got.size(), 5);
    tick(0, 0, 1);
    tick(0, 0, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_triggered", triggered, 0);

    // Randomized captures after the reset.
    for (int r = 0; r < 3; r++) begin
      d    = int'($urandom_range(0, 2));
      lvl  = 8'($urandom_range(32, 224));
      fall = 1'($urandom_range(0, 1));
      startCapture(3, d, lvl, fall, 8'h00, 0);
      runCapture($sformatf("rand%0d", r), d, lvl, fall, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_trigger_capture.md
Name: adc_trigger_capture

Overview:
- Parametrised successor to the free-running periodic ADC sampler. Samples the parallel ADC bus at a programmable decimated rate into a circular buffer, with a pre-trigger history.
- Arms on command and detects a level-crossing trigger (rising or falling), or accepts a forced trigger. Captures a fixed post-trigger window.
- Then streams the whole record, oldest sample first, over a valid/ready byte-stream port. That port feeds the UART transmit path.

Parameters:
DATA_W, 8, ADC sample width in bits.
DEPTH, 256, record length in samples. Power of 2, >= 4. Address width = $clog2(DEPTH).
PRETRIG, 64, samples kept before the trigger sample. Range 1..DEPTH-1.
DECIM_W, 16, width of the decimation control.

Ports:
clk  in  1  system clock (ADC clock domain, one clock only).
rst  in  1  synchronous active-high reset.
adc_in  in  DATA_W  ADC sample bus, MSB = bit DATA_W-1, sampled on clk.
arm  in  1  single-cycle request to start a capture. Honoured only in IDLE.
force_trig  in  1  level. In WAIT_TRIG, triggers on the current sample strobe.
trig_level  in  DATA_W  trigger threshold, unsigned.
trig_falling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger.
decim  in  DECIM_W  sample strobe every decim+1 clocks. Latched at arm.
out_data  out  DATA_W  readout sample.
out_valid  out  1  out_data is valid.
out_ready  in  1  downstream accepts a word when out_valid && out_ready.
out_last  out  1  high with the final (DEPTH-th) readout word.
busy  out  1  high in any state except IDLE.
triggered  out  1  high from the trigger sample until the return to IDLE.
done  out  1  one-cycle pulse on the cycle the last word is accepted.

Behaviour:
Reset (rst = 1 at a clk edge, from any state including mid-readout):
- All outputs go to 0, state goes to IDLE.
- Write pointer, read counter, decimation counter and prev-sample-valid flag clear.
- Buffer contents are don't-care.

Sample strobe (stb):
- Decimation counter clears on an accepted arm.
- stb = (counter == decim_latched). The counter wraps to 0 on stb, otherwise increments.
- decim = 0 gives stb every clock. The first stb occurs decim_latched+1 clocks after arm.

On each stb in PRE, WAIT_TRIG or POST:
- adc_in is written to buf[wptr]; wptr increments modulo DEPTH.
- prev takes the sample value; prev_ok is set.

Trigger condition, evaluated on stb in WAIT_TRIG only, against the current sample cur:
- Rising: prev_ok && prev < trig_level && cur >= trig_level.
- Falling: prev_ok && prev > trig_level && cur <= trig_level.
- force_trig = 1 on that stb also triggers.

States:
- IDLE: arm moves to PRE, loading pre_cnt = 0.
- PRE: each stb increments pre_cnt. Triggers are ignored. After the PRETRIG-th stb, go to WAIT_TRIG.
- WAIT_TRIG: samples continue circularly, overwriting the oldest. On trigger:
  - the triggering sample is written as post-sample 1;
  - triggered is set;
  - post_cnt = 1;
  - go to POST.
  - If DEPTH-PRETRIG == 1, go directly to READOUT.
- POST: each stb increments post_cnt. When post_cnt reaches DEPTH-PRETRIG, sampling stops and the state goes to READOUT. wptr then points at the oldest sample.
- READOUT:
  - raddr starts at wptr and streams DEPTH words, incrementing modulo DEPTH.
  - First out_valid is no later than 2 clocks after entering READOUT.
  - out_data, out_valid and out_last are held stable while out_valid && !out_ready.
  - Sustained throughput is one word per clock when out_ready is held high. Synchronous-read RAM with a prefetch/skid register is allowed.
  - On acceptance of the word with out_last: done pulses, then go to IDLE with busy = 0 and triggered = 0 on the next cycle.

Other rules:
- arm outside IDLE is ignored.
- Inputs trig_level and trig_falling are used live. decim is latched.
- Comparisons are unsigned, DATA_W bits.

Test Plan (DEPTH=16, PRETRIG=4, DATA_W=8 unless noted):
- Ramp adc_in = cycle count mod 256, decim=0, trig_level=0x80, rising, arm at adc_in=0x10, out_ready=1 -> 16 words 0x7C,0x7D,0x7E,0x7F,0x80..0x8B; out_last on 0x8B; done pulses once; busy falls the next cycle.
- Same ramp, decim=3 (stb every 4 clocks, aligned so that 0x80 is sampled) -> 0x70,0x74,0x78,0x7C,0x80,0x84..0xAC.
- Falling trigger: descending ramp 0xFF down, trig_level=0x40 -> trigger sample 0x40; record 0x44..0x41 followed by 0x40..0x35.
- Constant adc_in=0x20 with trig_level=0x80: no trigger after 1000 clocks (busy=1, triggered=0). Then assert force_trig for 1 clock -> record of 16 × 0x20 streamed out.
- Backpressure: scenario 1 with out_ready random, ~50% duty -> exactly the same 16 words in order; out_data stable whenever valid && !ready; no duplicates.
- Reset/arm robustness:
  - arm pulsed during POST and during READOUT -> ignored.
  - rst asserted mid-READOUT (after 5 words) -> next cycle: out_valid=0, busy=0, triggered=0.
  - A new arm afterwards -> a correct full record.
